tc_register_bank: RTL and testbench

TC_REGISTER_BANK -- requirements
Module: tc_register_bank

---
 rtl/tc_register_bank.sv | 95 +++++++++
 tb/tb_tc_register_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_register_bank.sv
// ============================================================================
// Module   : tc_register_bank
// Brief    : Register bank with falling-edge writes and two registered read
//            ports updated on the rising edge. Optional same-cycle write-to-read
//            forwarding is enabled by defining TC_REGISTER_BANK_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_register_bank #(
    parameter int BIT_WIDTH  = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  save,
    input  logic [ADDR_WIDTH-1:0] save_addr,
    input  logic [BIT_WIDTH-1:0]  in,
    input  logic                  load_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  load_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [BIT_WIDTH-1:0]  out_a,
    output logic [BIT_WIDTH-1:0]  out_b
);

    // Declaration initialisers give the zero power-up state.
    logic [BIT_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic                 r_rst_q       = 1'b0;
    logic [BIT_WIDTH-1:0] r_out_a       = '0;
    logic [BIT_WIDTH-1:0] r_out_b       = '0;

    logic [BIT_WIDTH-1:0] w_rd_a;
    logic [BIT_WIDTH-1:0] w_rd_b;
    logic                 w_save_valid;

    // Addresses at or beyond DEPTH never match an entry, so such reads
    // return zero and such writes fall on the floor.
    always_comb begin
        w_rd_a       = '0;
        w_rd_b       = '0;
        w_save_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_a == ADDR_WIDTH'(i)) w_rd_a = r_mem[i];
            if (addr_b == ADDR_WIDTH'(i)) w_rd_b = r_mem[i];
            if (save_addr == ADDR_WIDTH'(i)) w_save_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    // The delayed reset clears the array half a cycle after outputs clear.
    always_ff @(negedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_rst_q) begin
                r_mem[i] <= '0;
            end else if (save && (save_addr == ADDR_WIDTH'(i))) begin
                r_mem[i] <= in;
            end
        end
    end

`ifdef TC_REGISTER_BANK_BYPASS_EN
    logic w_fwd_a;
    logic w_fwd_b;
    assign w_fwd_a = save && w_save_valid && (save_addr == addr_a);
    assign w_fwd_b = save && w_save_valid && (save_addr == addr_b);
`else
    logic w_fwd_a;
    logic w_fwd_b;
    logic w_unused_valid;
    assign w_fwd_a        = 1'b0;
    assign w_fwd_b        = 1'b0;
    assign w_unused_valid = w_save_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_a <= '0;
            r_out_b <= '0;
        end else begin
            if (load_a) r_out_a <= w_fwd_a ? in : w_rd_a;
            if (load_b) r_out_b <= w_fwd_b ? in : w_rd_b;
        end
    end

    assign out_a = r_out_a;
    assign out_b = r_out_b;

endmodule

`default_nettype wire

// File: tb/tb_tc_register_bank.sv
// ============================================================================
// Module   : tb_tc_register_bank
// Brief    : Scoreboard testbench for tc_register_bank (8-bit x 8 entries,
//            4-bit addresses so out-of-range accesses can be exercised).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tc_register_bank;

    localparam int c_bw    = 8;
    localparam int c_depth = 8;
    localparam int c_aw    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              save = 1'b0;
    logic [c_aw-1:0]   save_addr = '0;
    logic [c_bw-1:0]   in = '0;
    logic              load_a = 1'b0;
    logic [c_aw-1:0]   addr_a = '0;
    logic              load_b = 1'b0;
    logic [c_aw-1:0]   addr_b = '0;
    logic [c_bw-1:0]   out_a;
    logic [c_bw-1:0]   out_b;

    tc_register_bank #(
        .BIT_WIDTH (c_bw),
        .DEPTH     (c_depth),
        .ADDR_WIDTH(c_aw)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .save     (save),
        .save_addr(save_addr),
        .in       (in),
        .load_a   (load_a),
        .addr_a   (addr_a),
        .load_b   (load_b),
        .addr_b   (addr_b),
        .out_a    (out_a),
        .out_b    (out_b)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [c_bw-1:0] m_mem [c_depth];
    logic [c_bw-1:0] m_out_a = '0;
    logic [c_bw-1:0] m_out_b = '0;

    // Scoreboard: expected pairs pushed at drive time, observations after the edge
    logic [2*c_bw-1:0] exp_q [$];
    logic [2*c_bw-1:0] obs_q [$];

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [c_bw-1:0] model_rd(input logic [c_aw-1:0] a);
        return (int'(a) < c_depth) ? m_mem[a[2:0]] : '0;
    endfunction

    function automatic logic model_fwd(input logic sv, input logic [c_aw-1:0] sa,
                                       input logic [c_aw-1:0] ra);
`ifdef TC_REGISTER_BANK_BYPASS_EN
        return sv && (sa == ra) && (int'(sa) < c_depth);
`else
        return 1'b0 && sv && (sa == ra);
`endif
    endfunction

    // One clock cycle: inputs change just after the falling edge, the rising
    // edge reads, and the following falling edge performs the write.
    task automatic step(input logic r, input logic sv, input logic [c_aw-1:0] sa,
                        input logic [c_bw-1:0] d, input logic la, input logic [c_aw-1:0] aa,
                        input logic lb, input logic [c_aw-1:0] ab);
        @(negedge clk);
        #1;
        rst = r; save = sv; save_addr = sa; in = d;
        load_a = la; addr_a = aa; load_b = lb; addr_b = ab;
        if (r) begin
            m_out_a = '0;
            m_out_b = '0;
        end else begin
            if (la) m_out_a = model_fwd(sv, sa, aa) ? d : model_rd(aa);
            if (lb) m_out_b = model_fwd(sv, sa, ab) ? d : model_rd(ab);
        end
        exp_q.push_back({m_out_a, m_out_b});
        @(posedge clk);
        #1;
        obs_q.push_back({out_a, out_b});
        if (r) begin
            for (int i = 0; i < c_depth; i++) m_mem[i] = '0;
        end else if (sv && int'(sa) < c_depth) begin
            m_mem[sa[2:0]] = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset;
        logic [2*c_bw-1:0] e, o;
        step(1'b1, 1'b0, '0, '0, 1'b1, 4'd0, 1'b1, 4'd1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd0, 1'b1, 4'd7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL test_reset: out_a/out_b=%h required %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_basic_write_read;
        logic [2*c_bw-1:0] e, o;
        step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd3, 1'b0, '0);
        step(1'b0, 1'b1, 4'd0, 8'hC3, 1'b0, '0, 1'b1, 4'd3);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd0, 1'b0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL test_basic_write_read: out_a/out_b=%h required %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range;
        logic [2*c_bw-1:0] e, o;
        step(1'b0, 1'b1, 4'd7, 8'h3C, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 4'd9, 8'h3C, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 4'd15, 8'hEE, 1'b1, 4'd7, 1'b1, 4'd9);
        for (int i = 0; i < c_depth; i += 2) begin
            step(1'b0, 1'b0, '0, '0, 1'b1, c_aw'(i), 1'b1, c_aw'(i + 1));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL test_out_of_range: out_a/out_b=%h required %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_dual_port;
        logic [2*c_bw-1:0] e, o;
        step(1'b0, 1'b1, 4'd4, 8'h5A, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd4, 1'b1, 4'd4);
        step(1'b0, 1'b0, '0, '0, 1'b0, 4'd3, 1'b1, 4'd7);
        step(1'b0, 1'b0, '0, '0, 1'b0, 4'd0, 1'b0, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL test_dual_port: out_a/out_b=%h required %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_clears_bank;
        logic [2*c_bw-1:0] e, o;
        for (int i = 0; i < c_depth; i++) begin
            step(1'b0, 1'b1, c_aw'(i), c_bw'((i + 1) * 8'h11), 1'b0, '0, 1'b0, '0);
        end
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd2, 1'b1, 4'd7);
        step(1'b1, 1'b1, 4'd2, 8'hFF, 1'b1, 4'd2, 1'b1, 4'd5);
        for (int i = 0; i < c_depth; i += 2) begin
            step(1'b0, 1'b0, '0, '0, 1'b1, c_aw'(i), 1'b1, c_aw'(i + 1));
        end
        step(1'b0, 1'b1, 4'd6, 8'h9D, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd6, 1'b1, 4'd2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL test_reset_clears_bank: out_a/out_b=%h required %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_bypass;
        logic [2*c_bw-1:0] e, o;
        step(1'b0, 1'b1, 4'd1, 8'h22, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 4'd1, 8'h77, 1'b1, 4'd1, 1'b1, 4'd2);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd1, 1'b0, '0);
        step(1'b1, 1'b1, 4'd3, 8'h44, 1'b1, 4'd3, 1'b1, 4'd3);
        step(1'b0, 1'b1, 4'd12, 8'h66, 1'b1, 4'd12, 1'b0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL test_bypass: out_a/out_b=%h required %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [2*c_bw-1:0] e, o;
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 c_aw'($urandom_range(0, 11)), c_bw'($urandom),
                 $urandom_range(0, 3) != 0, c_aw'($urandom_range(0, 11)),
                 $urandom_range(0, 3) != 0, c_aw'($urandom_range(0, 11)));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL test_back_to_back: out_a/out_b=%h required %h", o, e);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < c_depth; i++) m_mem[i] = '0;
        test_reset();
        test_basic_write_read();
        test_out_of_range();
        test_dual_port();
        test_reset_clears_bank();
        test_bypass();
        test_back_to_back();
        idle(1);
        while (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(obs_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

`default_nettype wire
